// File: rtl/square_fixed_point.sv
// Sequential unsigned fixed-point squarer: shift-and-add, one multiplier bit per clock.
// Result is x*x >> FRAC_W in the operand's Q format, saturated to all-ones on overflow.
module square_fixed_point #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_overflow,
    output logic              o_busy
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q, mplier_q;
    logic [PROD_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic                ovf_q;

    logic                accept;
    logic                last_bit;
    logic [PROD_W-1:0]   partial;
    logic [PROD_W-1:0]   sum;
    logic [PROD_W-1:0]   shifted;
    logic                overflow;
    logic [DATA_W-1:0]   result;

    assign accept   = i_valid && (state_q == IDLE);
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

    // The final CALC edge loads the outputs from this sum, not from acc_q.
    assign partial  = mplier_q[cnt_q] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
    assign sum      = acc_q + partial;
    assign shifted  = sum >> FRAC_W;
    assign overflow = |shifted[PROD_W-1:DATA_W];
    assign result   = overflow ? '1 : shifted[DATA_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
            DONE:    if (i_ready)  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            mcand_q  <= i_data;
            mplier_q <= i_data;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == CALC) begin
            acc_q <= sum;
            cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
                data_q <= result;
                ovf_q  <= overflow;
            end
        end
    end

    always_comb begin
        o_ready    = (state_q == IDLE);
        o_busy     = (state_q != IDLE);
        o_valid    = (state_q == DONE);
        o_data     = data_q;
        o_overflow = ovf_q;
    end

endmodule
